// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 digit multiplier.
package mult_pkg;

  // One radix-4 digit is 2 bits; a digit product is at most 3*3 = 9, so 4 bits.
  localparam int DIGIT_W = 2;
  localparam int DPROD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of radix-4 digits in an operand of the given width.
  function automatic int num_digits(input int width);
    return width / DIGIT_W;
  endfunction

  // Number of digit-pair iterations for a full product.
  function automatic int num_iters(input int width);
    return num_digits(width) * num_digits(width);
  endfunction

  // Digit counter width; a single-digit operand still needs a 1-bit counter.
  function automatic int ctr_w(input int nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

endpackage

// File: rtl/mul2x2_exact.sv
// Exact combinational 2x2-bit unsigned multiplier (one radix-4 digit pair).
module mul2x2_exact
  import mult_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DPROD_W-1:0] p
);

  logic pp_00, pp_10, pp_01, pp_11, carry1;

  // Partial products summed column by column; 3*3 = 4'b1001 exercises both carries.
  always_comb begin
    pp_00  = a[0] & b[0];
    pp_10  = a[1] & b[0];
    pp_01  = a[0] & b[1];
    pp_11  = a[1] & b[1];
    carry1 = pp_10 & pp_01;
    p[0]   = pp_00;
    p[1]   = pp_10 ^ pp_01;
    p[2]   = pp_11 ^ carry1;
    p[3]   = pp_11 & carry1;
  end

endmodule

// File: rtl/iter_digit_mult.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 2x2 digit product per cycle,
// shifted into a 2*WIDTH accumulator, with valid/ready on both sides.
module iter_digit_mult
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int ND = num_digits(WIDTH);
  localparam int CW = ctr_w(ND);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d, p_q, p_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;

  logic                accept, last_pair, is_zero;
  logic [DIGIT_W-1:0]  a_dig, b_dig;
  logic [DPROD_W-1:0]  dprod;
  logic [PW-1:0]       term;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_pair = (i_q == LAST) && (j_q == LAST);
  assign is_zero   = (a == '0) || (b == '0);

  // Select the current digit pair from the latched operands.
  always_comb begin
    a_dig = a_q[DIGIT_W*i_q +: DIGIT_W];
    b_dig = b_q[DIGIT_W*j_q +: DIGIT_W];
  end

  mul2x2_exact u_mul (
    .a (a_dig),
    .b (b_dig),
    .p (dprod)
  );

  // Zero-extend the digit product and weight it by radix-4 position i+j.
  always_comb begin
    term = PW'(dprod) << (DIGIT_W * (int'(i_q) + int'(j_q)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (ZERO_SKIP && is_zero) ? DONE : RUN;
      RUN:  if (last_pair) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    p         = p_q;
  end

  // Datapath next values: operand latch, accumulate, i inner / j outer counting.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    p_d   = p_q;
    i_d   = i_q;
    j_d   = j_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          p_d   = '0;
          i_d   = '0;
          j_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + term;
        if (last_pair) begin
          p_d = acc_q + term;
          i_d = '0;
          j_d = '0;
        end else if (i_q == LAST) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      p_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      p_q   <= p_d;
      i_q   <= i_d;
      j_q   <= j_d;
    end
  end

endmodule

// File: tb/tb_iter_digit_mult.sv
// Scoreboard bench for iter_digit_mult: 8-bit with and without zero skip, and 2-bit exhaustive.
module tb_iter_digit_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit DUTs share operands; sel steers valid/ready and output observation.
  logic        sel = 1'b0;
  logic        iv = 1'b0, ordy = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        iv0, iv1, or0, or1;
  logic        ir0, ov0, busy0, ir1, ov1, busy1;
  logic [15:0] p0, p1;
  logic        cur_ir, cur_ov, cur_busy;
  logic [15:0] cur_p;

  assign iv0 = iv && !sel;
  assign iv1 = iv && sel;
  assign or0 = ordy && !sel;
  assign or1 = ordy && sel;
  assign cur_ir   = sel ? ir1 : ir0;
  assign cur_ov   = sel ? ov1 : ov0;
  assign cur_busy = sel ? busy1 : busy0;
  assign cur_p    = sel ? p1 : p0;

  logic       iv2 = 1'b0, or2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ir2, ov2, busy2;
  logic [3:0] p2;

  iter_digit_mult #(.WIDTH(8), .ZERO_SKIP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(or0), .p(p0), .busy(busy0));

  iter_digit_mult #(.WIDTH(8), .ZERO_SKIP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1));

  iter_digit_mult #(.WIDTH(2), .ZERO_SKIP(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .p(p2), .busy(busy2));

  int total = 0;
  int bad = 0;
  logic [15:0] sb_q[$];
  logic [3:0]  sb2_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // One 8-bit transaction: push expectation at handshake, pop when the product appears.
  // exp_edges: clock edges from the handshake edge until out_valid is seen high.
  task automatic run8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input int exp_edges, input int exp_busy, input int stall);
    int edges;
    int busy_n;
    sel  = s;
    a    = av;
    b    = bv;
    iv   = 1'b1;
    ordy = 1'b0;
    check_val("in_ready_idle", 32'(cur_ir), 32'd1);
    sb_q.push_back({8'd0, av} * {8'd0, bv});
    @(negedge clk);
    iv     = 1'b0;
    a      = 8'hEE;
    b      = 8'hEE;
    edges  = 0;
    busy_n = 0;
    while (!cur_ov && edges < 200) begin
      if (cur_busy) busy_n++;
      @(negedge clk);
      edges++;
    end
    check_val("latency", 32'(edges), 32'(exp_edges));
    check_val("busy_cycles", 32'(busy_n), 32'(exp_busy));
    for (int k = 0; k < stall; k++) begin
      check_val("bp_p", 32'(cur_p), 32'(sb_q[0]));
      check_val("bp_in_ready", 32'(cur_ir), 32'd0);
      check_val("bp_out_valid", 32'(cur_ov), 32'd1);
      @(negedge clk);
    end
    check_val("product", 32'(cur_p), 32'(sb_q.pop_front()));
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check_val("out_valid_drop", 32'(cur_ov), 32'd0);
    check_val("back_to_idle", 32'(cur_ir), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saw_ov;
    logic [7:0] ra, rb;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", 32'(ir0), 32'd1);
    check_val("rst_out_valid", 32'(ov0), 32'd0);
    check_val("rst_busy", 32'(busy0), 32'd0);
    check_val("rst_p", 32'(p0), 32'd0);
    check_val("rst_w2_out_valid", 32'(ov2), 32'd0);

    run8(1'b0, 8'hFF, 8'hFF, 16, 16, 0);
    run8(1'b0, 8'hA5, 8'h3C, 16, 16, 10);
    run8(1'b0, 8'h00, 8'h7F, 0, 0, 0);
    run8(1'b1, 8'h00, 8'h7F, 16, 16, 0);
    run8(1'b1, 8'hA5, 8'h3C, 16, 16, 0);
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(1, 255));
      rb = 8'($urandom_range(0, 255));
      run8(1'b0, ra, rb, (rb == 8'd0) ? 0 : 16, (rb == 8'd0) ? 0 : 16, 0);
    end

    // Reset seven iterations into a=0x12, b=0x34: the operation must vanish.
    sel = 1'b0;
    a   = 8'h12;
    b   = 8'h34;
    iv  = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_ov = 0;
    for (int k = 0; k < 25; k++) begin
      if (ov0) saw_ov = 1;
      @(negedge clk);
    end
    check_val("abort_no_out_valid", 32'(saw_ov), 32'd0);
    check_val("abort_in_ready", 32'(ir0), 32'd1);
    run8(1'b0, 8'd3, 8'd3, 16, 16, 0);

    // WIDTH=2 exhaustive, back-to-back with the consumer always ready.
    or2 = 1'b1;
    fork
      begin
        int w;
        for (int k = 0; k < 16; k++) begin
          a2  = 2'(k >> 2);
          b2  = 2'(k);
          iv2 = 1'b1;
          w   = 0;
          while (!ir2 && w < 20) begin
            @(negedge clk);
            w++;
          end
          if (w >= 20) break;
          sb2_q.push_back({2'b00, a2} * {2'b00, b2});
          @(negedge clk);
        end
        iv2 = 1'b0;
      end
      begin
        int w;
        for (int k = 0; k < 16; k++) begin
          w = 0;
          while (!ov2 && w < 20) begin
            @(negedge clk);
            w++;
          end
          check_val("w2_out_valid", 32'(ov2), 32'd1);
          if (!ov2 || sb2_q.size() == 0) break;
          check_val("w2_product", 32'(p2), 32'(sb2_q.pop_front()));
          @(negedge clk);
        end
      end
    join
    check_val("w2_scoreboard_empty", 32'(sb2_q.size()), 32'd0);
    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
